// File: rtl/mul_reservation_station_pkg.sv
// Shared types for the multiplier reservation station.
// Entry state, the entry record and the "operand valid" tag value.
package mul_rs_pkg;

    localparam int RS_DATA_W = 32;
    localparam int RS_TAG_W  = 4;
    // Wide enough for any RS_DEPTH up to 8; unused upper bits stay zero.
    localparam int RS_AGE_W  = 3;

    localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        EXEC  = 2'd3
    } rs_state_t;

    typedef struct packed {
        rs_state_t               state;
        logic                    op_hi;
        logic [RS_DATA_W-1:0]    vj;
        logic [RS_TAG_W-1:0]     qj;
        logic [RS_DATA_W-1:0]    vk;
        logic [RS_TAG_W-1:0]     qk;
        logic [RS_AGE_W-1:0]     age;
    } rs_entry_t;

endpackage

// File: rtl/mul_reservation_station_if.sv
// Dispatch, CDB and multiplier-side signals of the MUL reservation station.
// master = dispatch/CDB/multiplier environment, slave = the reservation station.
interface mul_reservation_station_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic              disp_valid;
    logic              disp_ready;
    logic              disp_op_hi;
    logic [DATA_W-1:0] disp_vj;
    logic [TAG_W-1:0]  disp_qj;
    logic [DATA_W-1:0] disp_vk;
    logic [TAG_W-1:0]  disp_qk;
    logic [TAG_W-1:0]  disp_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              mul_start;
    logic [DATA_W-1:0] mul_src_a;
    logic [DATA_W-1:0] mul_src_b;
    logic [TAG_W-1:0]  mul_tag;
    logic              mul_op_hi;
    logic              unit_busy;

    modport master (
        output disp_valid, disp_op_hi, disp_vj, disp_qj, disp_vk, disp_qk,
               cdb_valid, cdb_tag, cdb_data,
        input  disp_ready, disp_tag, mul_start, mul_src_a, mul_src_b,
               mul_tag, mul_op_hi, unit_busy
    );

    modport slave (
        input  disp_valid, disp_op_hi, disp_vj, disp_qj, disp_vk, disp_qk,
               cdb_valid, cdb_tag, cdb_data,
        output disp_ready, disp_tag, mul_start, mul_src_a, mul_src_b,
               mul_tag, mul_op_hi, unit_busy
    );
endinterface

// File: rtl/mul_reservation_station_pick_ready.sv
// Combinational picker: among masked entries choose the one with the
// largest age, ties going to the lowest index. With all-zero ages this is
// a plain lowest-index priority select.
module rs_pick_ready
    import mul_rs_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]               mask,
    input  logic [N-1:0][RS_AGE_W-1:0] ages,
    output logic [IDX_W-1:0]           idx,
    output logic                       found
);
    logic [RS_AGE_W-1:0] best_age;

    // Scan upward, replacing the pick only on a strictly older entry.
    always_comb begin
        idx      = '0;
        found    = 1'b0;
        best_age = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && (!found || (ages[i] > best_age))) begin
                found    = 1'b1;
                idx      = IDX_W'(i);
                best_age = ages[i];
            end
        end
    end
endmodule

// File: rtl/mul_reservation_station.sv
// Reservation station in front of the iterative multiplier.
// Allocates tags TAG_BASE+idx on dispatch, snoops the CDB for missing
// operands, issues one ready op at a time and frees it when the result
// for its tag appears on the CDB.
// Optional build macro MUL_RS_AGE_ORDER_EN: issue the oldest READY entry
// instead of the lowest-index one.
module mul_reservation_station
    import mul_rs_pkg::*;
#(
    parameter int               RS_DEPTH = 3,
    parameter int               TAG_W    = RS_TAG_W,
    parameter int               DATA_W   = RS_DATA_W,
    parameter logic [TAG_W-1:0] TAG_BASE = TAG_W'(8)
) (
    input  logic                     clk,
    input  logic                     reset,
    mul_reservation_station_if.slave rs
);
    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    rs_entry_t                         entries_q [RS_DEPTH];
    rs_entry_t                         entries_n [RS_DEPTH];
    rs_entry_t                         entries_d [RS_DEPTH];
    rs_entry_t                         ent;
    logic                              busy_q, busy_n, busy_d;
    logic                              mul_start_q, mul_start_d;
    logic [DATA_W-1:0]                 mul_src_a_q, mul_src_a_d;
    logic [DATA_W-1:0]                 mul_src_b_q, mul_src_b_d;
    logic [TAG_W-1:0]                  mul_tag_q, mul_tag_d;
    logic                              mul_op_hi_q, mul_op_hi_d;
    logic [IDX_W-1:0]                  exec_idx_q, exec_idx_d;
    logic [RS_DEPTH-1:0]               free_mask, ready_mask;
    logic [RS_DEPTH-1:0][RS_AGE_W-1:0] zero_ages, ages_n;
    logic [IDX_W-1:0]                  alloc_idx, issue_idx;
    logic                              alloc_found, issue_found;
    logic                              disp_fire, complete;
`ifdef MUL_RS_AGE_ORDER_EN
    logic [RS_AGE_W-1:0]               freed_age;
`endif

    assign zero_ages = '0;

    // Free entries come from registered state only, so disp_ready is flop-driven.
    always_comb begin
        free_mask = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            free_mask[i] = (entries_q[i].state == FREE);
        end
    end

    rs_pick_ready #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_pick_free (
        .mask(free_mask), .ages(zero_ages), .idx(alloc_idx), .found(alloc_found)
    );

    // Entry update from snoop, completion and dispatch, ahead of issue.
    always_comb begin
        disp_fire  = rs.disp_valid && alloc_found;
        complete   = rs.cdb_valid && busy_q && (rs.cdb_tag == mul_tag_q);
`ifdef MUL_RS_AGE_ORDER_EN
        freed_age  = entries_q[exec_idx_q].age;
`endif
        ready_mask = '0;
        ages_n     = '0;
        ent        = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent = entries_q[i];
            if (ent.state == WAIT && rs.cdb_valid) begin
                if (ent.qj != TAG_NONE && ent.qj == rs.cdb_tag) begin
                    ent.vj = rs.cdb_data;
                    ent.qj = TAG_NONE;
                end
                if (ent.qk != TAG_NONE && ent.qk == rs.cdb_tag) begin
                    ent.vk = rs.cdb_data;
                    ent.qk = TAG_NONE;
                end
                if (ent.qj == TAG_NONE && ent.qk == TAG_NONE) ent.state = READY;
            end
`ifdef MUL_RS_AGE_ORDER_EN
            // Ages stay a dense 0..n-1 ranking: bump on dispatch, close the gap on free.
            if (ent.state != FREE && !(complete && exec_idx_q == IDX_W'(i))) begin
                ent.age = ent.age + RS_AGE_W'(disp_fire)
                        - RS_AGE_W'(complete && (ent.age > freed_age));
            end
`endif
            if (complete && exec_idx_q == IDX_W'(i)) ent.state = FREE;
            if (disp_fire && alloc_idx == IDX_W'(i)) begin
                ent.op_hi = rs.disp_op_hi;
                ent.vj    = rs.disp_vj;
                ent.qj    = rs.disp_qj;
                ent.vk    = rs.disp_vk;
                ent.qk    = rs.disp_qk;
                ent.age   = '0;
                if (rs.cdb_valid && rs.disp_qj != TAG_NONE && rs.disp_qj == rs.cdb_tag) begin
                    ent.vj = rs.cdb_data;
                    ent.qj = TAG_NONE;
                end
                if (rs.cdb_valid && rs.disp_qk != TAG_NONE && rs.disp_qk == rs.cdb_tag) begin
                    ent.vk = rs.cdb_data;
                    ent.qk = TAG_NONE;
                end
                ent.state = (ent.qj == TAG_NONE && ent.qk == TAG_NONE) ? READY : WAIT;
            end
            entries_n[i]  = ent;
            ready_mask[i] = (ent.state == READY);
            ages_n[i]     = ent.age;
        end
        busy_n = busy_q && !complete;
    end

    rs_pick_ready #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_pick_issue (
        .mask(ready_mask), .ages(ages_n), .idx(issue_idx), .found(issue_found)
    );

    // Issue: a freshly ready entry starts with a registered pulse one cycle later.
    always_comb begin
        entries_d   = entries_n;
        busy_d      = busy_n;
        mul_start_d = 1'b0;
        mul_src_a_d = mul_src_a_q;
        mul_src_b_d = mul_src_b_q;
        mul_tag_d   = mul_tag_q;
        mul_op_hi_d = mul_op_hi_q;
        exec_idx_d  = exec_idx_q;
        if (!busy_n && issue_found) begin
            entries_d[issue_idx].state = EXEC;
            busy_d      = 1'b1;
            mul_start_d = 1'b1;
            mul_src_a_d = entries_n[issue_idx].vj;
            mul_src_b_d = entries_n[issue_idx].vk;
            mul_op_hi_d = entries_n[issue_idx].op_hi;
            mul_tag_d   = TAG_BASE + TAG_W'(issue_idx);
            exec_idx_d  = issue_idx;
        end
    end

    // State registers; reset drops every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RS_DEPTH; i++) entries_q[i] <= '0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_src_a_q <= '0;
            mul_src_b_q <= '0;
            mul_tag_q   <= '0;
            mul_op_hi_q <= 1'b0;
            exec_idx_q  <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) entries_q[i] <= entries_d[i];
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
            mul_src_a_q <= mul_src_a_d;
            mul_src_b_q <= mul_src_b_d;
            mul_tag_q   <= mul_tag_d;
            mul_op_hi_q <= mul_op_hi_d;
            exec_idx_q  <= exec_idx_d;
        end
    end

    assign rs.disp_ready = alloc_found;
    assign rs.disp_tag   = TAG_BASE + TAG_W'(alloc_idx);
    assign rs.mul_start  = mul_start_q;
    assign rs.mul_src_a  = mul_src_a_q;
    assign rs.mul_src_b  = mul_src_b_q;
    assign rs.mul_tag    = mul_tag_q;
    assign rs.mul_op_hi  = mul_op_hi_q;
    assign rs.unit_busy  = busy_q;
endmodule
